// File: rtl/hex_digit_scanner.sv
// rtl/hex_digit_scanner.sv - 4-digit seven-segment scan controller with frame-aligned double-buffered loads
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module hex_digit_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DpIn,
  input  logic        Blank,
  output logic [3:0]  HexVal,
  output logic [3:0]  Anodes,
  output logic        Dp,
  output logic        Pending,
  output logic        FrameTick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;
  logic          pending_q;
  logic          frame_tick_q;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    lz_off;

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == 2'd3);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt          <= '0;
      idx          <= 2'd0;
      shadow_val   <= 16'd0;
      shadow_dp    <= 4'd0;
      disp_val     <= 16'd0;
      disp_dp      <= 4'd0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_tick_q <= wrap;

      // A load landing on the wrap edge bypasses the shadow and wins over any older pending load.
      if (Load && wrap) begin
        shadow_val <= Value;
        shadow_dp  <= DpIn;
        disp_val   <= Value;
        disp_dp    <= DpIn;
        pending_q  <= 1'b0;
      end else if (wrap) begin
        if (pending_q) begin
          disp_val <= shadow_val;
          disp_dp  <= shadow_dp;
        end
        pending_q <= 1'b0;
      end else if (Load) begin
        shadow_val <= Value;
        shadow_dp  <= DpIn;
        pending_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    lz_off = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz_off[1] = (disp_val[15:4]  == 12'd0);
    lz_off[2] = (disp_val[15:8]  == 8'd0);
    lz_off[3] = (disp_val[15:12] == 4'd0);
`endif
  end

  always_comb begin
    HexVal = 4'd0;
    case (idx)
      2'd0:    HexVal = disp_val[3:0];
      2'd1:    HexVal = disp_val[7:4];
      2'd2:    HexVal = disp_val[11:8];
      default: HexVal = disp_val[15:12];
    endcase
  end

  always_comb begin
    Anodes = 4'b1111;
    if (!Blank && !lz_off[idx]) begin
      Anodes[idx] = 1'b0;
    end
  end

  assign Dp        = ~disp_dp[idx];
  assign Pending   = pending_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb/tb_hex_digit_scanner.sv - directed self-checking bench for hex_digit_scanner (SCAN_DIV = 4)
module tb_hex_digit_scanner;

  logic        Clk = 1'b0;
  logic        Reset, Load, Blank;
  logic [15:0] Value;
  logic [3:0]  DpIn;
  logic [3:0]  HexVal, Anodes;
  logic        Dp, Pending, FrameTick;

  int n_cmp  = 0;
  int n_fail = 0;
  int ph     = 0;

  hex_digit_scanner #(.SCAN_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Value(Value), .DpIn(DpIn), .Blank(Blank),
    .HexVal(HexVal), .Anodes(Anodes), .Dp(Dp), .Pending(Pending), .FrameTick(FrameTick)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
    ph++;
  endtask

  function automatic int cur();
    return (ph / 4) % 4;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    return v[i*4 +: 4];
  endfunction

  function automatic logic [3:0] an(input logic [15:0] v, input int i);
    logic [3:0] a;
    a    = 4'b1111;
    a[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (v >> (4 * i)) == 16'd0) a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic test_reset();
    int ticks;
    Reset = 1'b1; Load = 1'b0; Blank = 1'b0; Value = 16'd0; DpIn = 4'd0;
    repeat (3) step();
    Reset = 1'b0;
    ph = 0;
    n_cmp++; if (Anodes !== 4'b1110) begin n_fail++; $display("FAIL reset_anodes got %b exp 1110", Anodes); end
    n_cmp++; if (HexVal !== 4'h0) begin n_fail++; $display("FAIL reset_hexval got %h exp 0", HexVal); end
    n_cmp++; if (Dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b exp 1", Dp); end
    n_cmp++; if (Pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", Pending); end
    n_cmp++; if (FrameTick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", FrameTick); end
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (FrameTick === 1'b1) ticks++;
      if (k == 4) begin
        n_cmp++; if (Anodes !== 4'b1101) begin n_fail++; $display("FAIL first_advance got %b exp 1101", Anodes); end
      end
      if (k == 16) begin
        n_cmp++; if (FrameTick !== 1'b1) begin n_fail++; $display("FAIL first_tick got %b exp 1", FrameTick); end
      end
    end
    n_cmp++; if (ticks !== 1) begin n_fail++; $display("FAIL tick_count got %0d exp 1", ticks); end
  endtask

  task automatic test_load();
    Value = 16'h1A2F; DpIn = 4'b0100; Load = 1'b1;
    step();
    Load = 1'b0;
    while (ph < 32) begin
      n_cmp++; if (Pending !== 1'b1 || HexVal !== 4'h0) begin n_fail++; $display("FAIL load_hold ph=%0d got pend=%b hex=%h exp pend=1 hex=0", ph, Pending, HexVal); end
      step();
    end
    n_cmp++; if (FrameTick !== 1'b1 || Pending !== 1'b0) begin n_fail++; $display("FAIL load_commit got tick=%b pend=%b exp tick=1 pend=0", FrameTick, Pending); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (HexVal !== nib(16'h1A2F, cur()) || Anodes !== an(16'h1A2F, cur()) || Dp !== (cur() != 2)) begin
        n_fail++;
        $display("FAIL load_seq ph=%0d got hex=%h an=%b dp=%b exp hex=%h an=%b dp=%b", ph, HexVal, Anodes, Dp,
                 nib(16'h1A2F, cur()), an(16'h1A2F, cur()), (cur() != 2));
      end
      step();
    end
  endtask

  task automatic test_last_wins();
    step(); step();
    Value = 16'h1111; DpIn = 4'd0; Load = 1'b1;
    step();
    Value = 16'h2222;
    step();
    Load = 1'b0;
    n_cmp++; if (Pending !== 1'b1) begin n_fail++; $display("FAIL lw_pending got %b exp 1", Pending); end
    while (ph < 64) begin
      n_cmp++; if (HexVal !== nib(16'h1A2F, cur())) begin n_fail++; $display("FAIL lw_old ph=%0d got %h exp %h", ph, HexVal, nib(16'h1A2F, cur())); end
      step();
    end
    n_cmp++; if (Pending !== 1'b0 || FrameTick !== 1'b1) begin n_fail++; $display("FAIL lw_commit got pend=%b tick=%b exp pend=0 tick=1", Pending, FrameTick); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (HexVal !== 4'h2) begin n_fail++; $display("FAIL lw_seq ph=%0d got %h exp 2", ph, HexVal); end
      step();
    end
  endtask

  task automatic test_wrap_load();
    repeat (5) step();
    Value = 16'h1234; DpIn = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    while (ph < 95) step();
    n_cmp++; if (Pending !== 1'b1) begin n_fail++; $display("FAIL wl_pending got %b exp 1", Pending); end
    Value = 16'hBEEF; DpIn = 4'b1001; Load = 1'b1;
    step();
    Load = 1'b0;
    n_cmp++; if (HexVal !== 4'hF) begin n_fail++; $display("FAIL wl_hex got %h exp f", HexVal); end
    n_cmp++; if (Pending !== 1'b0) begin n_fail++; $display("FAIL wl_pend got %b exp 0", Pending); end
    n_cmp++; if (FrameTick !== 1'b1) begin n_fail++; $display("FAIL wl_tick got %b exp 1", FrameTick); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (HexVal !== nib(16'hBEEF, cur()) || Dp !== !(cur() == 0 || cur() == 3)) begin
        n_fail++;
        $display("FAIL wl_seq ph=%0d got hex=%h dp=%b exp hex=%h", ph, HexVal, Dp, nib(16'hBEEF, cur()));
      end
      step();
    end
  endtask

  task automatic test_blank_reset();
    Blank = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      n_cmp++;
      if (Anodes !== 4'b1111 || HexVal !== nib(16'hBEEF, cur())) begin
        n_fail++;
        $display("FAIL blank ph=%0d got an=%b hex=%h exp an=1111 hex=%h", ph, Anodes, HexVal, nib(16'hBEEF, cur()));
      end
    end
    Blank = 1'b0;
    #1;
    n_cmp++; if (Anodes !== 4'b1011) begin n_fail++; $display("FAIL unblank got %b exp 1011", Anodes); end
    Value = 16'h5555; Load = 1'b1;
    step();
    Load = 1'b0;
    n_cmp++; if (Pending !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pend got %b exp 1", Pending); end
    Reset = 1'b1;
    step();
    n_cmp++; if (Pending !== 1'b0) begin n_fail++; $display("FAIL rst_pend got %b exp 0", Pending); end
    n_cmp++; if (Anodes !== 4'b1110 || HexVal !== 4'h0) begin n_fail++; $display("FAIL rst_out got an=%b hex=%h exp an=1110 hex=0", Anodes, HexVal); end
    Reset = 1'b0;
    ph = 0;
  endtask

  task automatic test_leading_zero();
    Value = 16'h00A0; DpIn = 4'd0; Load = 1'b1;
    step();
    Load = 1'b0;
    while (ph < 16) step();
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (Anodes !== an(16'h00A0, cur()) || HexVal !== nib(16'h00A0, cur())) begin
        n_fail++;
        $display("FAIL lz_a0 ph=%0d got an=%b hex=%h exp an=%b hex=%h", ph, Anodes, HexVal, an(16'h00A0, cur()), nib(16'h00A0, cur()));
      end
      step();
    end
    Value = 16'h0000; Load = 1'b1;
    step();
    Load = 1'b0;
    while (ph < 48) step();
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (Anodes !== an(16'h0000, cur())) begin n_fail++; $display("FAIL lz_zero ph=%0d got %b exp %b", ph, Anodes, an(16'h0000, cur())); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_last_wins();
    test_wrap_load();
    test_blank_reset();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_digit_scanner.md
# hex_digit_scanner

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. Holds a 16-bit value plus decimal-point bits, cycles one digit at a time at a programmable rate, and drives the nibble for the active digit onto `HexVal`, which feeds the hex-to-seven-segment decoder directly. Loads are double-buffered and committed only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays active; legal range ≥ 2; prescaler width is `$clog2(SCAN_DIV)`.

- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load`  in  1  single-cycle strobe; captures `Value` and `DpIn` into the shadow register.
- `Value`  in  16  display value; nibble i drives digit i (digit 0 = `Value[3:0]`, rightmost).
- `DpIn`  in  4  decimal-point enables; bit i drives digit i; 1 = point lit.
- `Blank`  in  1  1 = all anodes off; scanning continues.
- `HexVal`  out  4  nibble of the active digit, to the segment decoder.
- `Anodes`  out  4  active-low digit enables; exactly one low when not blanked.
- `Dp`  out  1  active-low decimal point for the active digit.
- `Pending`  out  1  shadow register holds an uncommitted load.
- `FrameTick`  out  1  one-cycle pulse marking the start of each frame.

## Operation
- State: prescaler `Cnt`, 2-bit digit index `Idx`, shadow register (16+4 bits), display register (16+4 bits), `Pending` flag, `FrameTick` register.
- Prescaler: at each edge, if `Cnt == SCAN_DIV-1`, then `Cnt <= 0` and `Idx <= Idx+1` (wrapping 3→0). Otherwise `Cnt <= Cnt+1`.
- Wrap edge: the edge at which `Idx` goes from 3 to 0. At this edge:
  - `FrameTick <= 1`; at every other edge, `FrameTick <= 0`.
  - If `Pending` is set, the shadow register is copied into the display register and `Pending <= 0`.
- Load when not at a wrap edge: the shadow register captures `Value` and `DpIn`, and `Pending <= 1`. If a load is already pending, the new load overwrites it (last load wins).
- Load coincident with a wrap edge: the incoming `Value`/`DpIn` are written directly to both the shadow and display registers, and `Pending <= 0`. Any earlier pending load is discarded.
- Outputs are combinational from registered state plus `Blank`:
  - `HexVal` = display nibble `Idx`.
  - `Dp` = ~display dp bit `Idx`.
  - `Anodes` = ~(1 << `Idx`), or 4'b1111 when `Blank` = 1.
- Reset values: `Cnt` = 0, `Idx` = 0, shadow = 0, display = 0, `Pending` = 0, `FrameTick` = 0.
  - Resulting outputs: `HexVal` = 0, `Anodes` = 4'b1110, `Dp` = 1.
- Reset has priority over `Load` and over prescaler activity. Asserting it mid-frame discards any pending load.

## Timing
- Each digit is active for exactly `SCAN_DIV` cycles; a frame lasts 4·`SCAN_DIV` cycles.
- After reset release, the first `Idx` advance occurs at the `SCAN_DIV`-th edge.
- `HexVal`, `Anodes` and `Dp` change in the same cycle that `Idx` changes. There is no pipeline skew between them.
- `Blank` acts combinationally on `Anodes`, with zero-cycle latency.
- Load-to-visible latency: from 1 cycle (load at the wrap edge, visible in the following cycle) up to 4·`SCAN_DIV` cycles.
- `Pending` rises the cycle after a `Load` edge. It falls the cycle after the committing wrap edge.
- `FrameTick` is high for exactly the first cycle with `Idx` = 0 after a wrap. During that cycle the display register already holds the committed value.
- `FrameTick` does not pulse on reset release.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: a digit i > 0 has its anode forced high when display nibbles i..3 are all zero.
  - Digit 0 is always shown.
  - Scan timing is unchanged: blanked digits still occupy their `SCAN_DIV` slot.
- Undefined: all four digits are always driven, subject only to `Blank`.

## Test plan
All scenarios use `SCAN_DIV` = 4.

1. Reset for 3 cycles, then release:
   - `Anodes` = 1110, `HexVal` = 0, `Dp` = 1, `Pending` = 0.
   - 4 cycles later `Anodes` = 1101; after 16 cycles, `FrameTick` pulses once.
2. `Load` `Value` = 16'h1A2F, `DpIn` = 4'b0100 mid-frame:
   - `Pending` = 1 and the display is unchanged until the wrap.
   - After the wrap, `HexVal` sequences F, 2, A, 1 (4 cycles each).
   - `Dp` = 0 only while `Anodes` = 1011.
3. `Load` 16'h1111, then `Load` 16'h2222 before the wrap:
   - Only 2222 is ever displayed; `Pending` clears at the wrap.
4. `Load` 16'hBEEF on the exact wrap edge with an older value pending:
   - The next cycle shows `HexVal` = F, `Pending` = 0, `FrameTick` = 1.
   - The older value never appears.
5. `Blank` = 1 for 10 cycles, then `Blank` = 0, then `Reset` with `Pending` = 1:
   - While blanked, `Anodes` = 1111 and `Idx` keeps advancing.
   - On deassert, the digit resumes at the correct slot.
   - Reset clears `Pending` and restores `Anodes` = 1110 at the next edge.
6. With `LEADING_ZERO_BLANK_EN` defined:
   - `Value` = 16'h00A0: digits 3 and 2 have their anodes held high; digits 1 and 0 show A and 0.
   - `Value` = 16'h0000: only digit 0 is lit.
